// File: rtl/acc_ctrl.sv
// Accumulator-machine instruction controller: decodes one 16-bit word per handshake
// and sequences ALU, memory-read, skip and halt behaviour for the datapath.
module acc_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_instr_valid,
  input  logic [15:0]      i_instr,
  output logic             o_instr_ready,
  output logic [1:0]       o_data_src,
  output logic [2:0]       o_op,
  output logic [WIDTH-1:0] o_immediate,
  output logic [3:0]       o_reg_addr,
  output logic [7:0]       o_mem_addr,
  output logic             o_mem_rd,
  input  logic             i_mem_rvalid,
  output logic             o_ce_a,
  output logic             o_ce_cy,
  input  logic             i_flag_z,
  input  logic             i_flag_cy,
  output logic             o_halted,
  output logic             o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM = 2'b00,
    SRC_IMM = 2'b01,
    SRC_REG = 2'b11
  } data_src_t;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ALU_IMM = 4'h1;
  localparam logic [3:0] OP_ALU_REG = 4'h2;
  localparam logic [3:0] OP_ALU_MEM = 4'h3;
  localparam logic [3:0] OP_SKZ     = 4'h4;
  localparam logic [3:0] OP_SKC     = 4'h5;
  localparam logic [3:0] OP_HALT    = 4'hF;
  // Last wait cycle index: 15 MEM_WAIT cycles without data means timeout.
  localparam logic [3:0] WAIT_LAST  = 4'd14;

  state_t      r_state, w_state_next;
  logic [15:0] r_instr, w_instr_next;
  logic        r_skip, w_skip_next;
  logic [3:0]  r_wait_cnt, w_wait_cnt_next;
  logic        r_err, w_err_next;
  logic        w_hs;
  data_src_t   w_data_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_skip     <= 1'b0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_instr    <= w_instr_next;
      r_skip     <= w_skip_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_err      <= w_err_next;
    end
  end

  // Gating with rst_n keeps ready low while reset holds the FSM in IDLE.
  assign o_instr_ready = (r_state == S_IDLE) && rst_n;
  assign w_hs          = i_instr_valid && o_instr_ready;

  always_comb begin
    w_state_next    = r_state;
    w_instr_next    = r_instr;
    w_skip_next     = r_skip;
    w_wait_cnt_next = r_wait_cnt;
    w_err_next      = 1'b0;
    o_ce_a          = 1'b0;
    o_mem_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (r_skip) begin
            // Skipped word is swallowed whole: no latch update, no side effects.
            w_skip_next = 1'b0;
          end else begin
            w_instr_next = i_instr;
            case (i_instr[15:12])
              OP_NOP:                 ;
              OP_ALU_IMM, OP_ALU_REG: w_state_next = S_EXEC;
              OP_ALU_MEM:             w_state_next = S_MEM_REQ;
              OP_SKZ:                 w_skip_next  = i_flag_z;
              OP_SKC:                 w_skip_next  = i_flag_cy;
              OP_HALT:                w_state_next = S_HALT;
              default:                w_err_next   = 1'b1;
            endcase
          end
        end
      end
      S_EXEC: begin
        o_ce_a       = 1'b1;
        w_state_next = S_IDLE;
      end
      S_MEM_REQ: begin
        o_mem_rd        = 1'b1;
        w_wait_cnt_next = '0;
        w_state_next    = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (i_mem_rvalid) begin
          o_ce_a       = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 4'd1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_instr[15:12])
      OP_ALU_IMM: w_data_src = SRC_IMM;
      OP_ALU_REG: w_data_src = SRC_REG;
      default:    w_data_src = SRC_MEM;
    endcase
  end

  assign o_data_src  = w_data_src;
  assign o_op        = r_instr[10:8];
  assign o_immediate = WIDTH'(r_instr[7:0]);
  assign o_reg_addr  = r_instr[3:0];
  assign o_mem_addr  = r_instr[7:0];
  assign o_ce_cy     = o_ce_a && r_instr[11];
  assign o_halted    = (r_state == S_HALT);
  assign o_err       = r_err;

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed testbench for acc_ctrl: one task per feature, inline checks, one summary line.
module tb_acc_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_valid;
  logic [15:0]      instr;
  logic             instr_ready;
  logic [1:0]       data_src;
  logic [2:0]       op;
  logic [WIDTH-1:0] immediate;
  logic [3:0]       reg_addr;
  logic [7:0]       mem_addr;
  logic             mem_rd;
  logic             mem_rvalid;
  logic             ce_a;
  logic             ce_cy;
  logic             flag_z;
  logic             flag_cy;
  logic             halted;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  acc_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_instr_valid(instr_valid), .i_instr(instr), .o_instr_ready(instr_ready),
    .o_data_src(data_src), .o_op(op), .o_immediate(immediate),
    .o_reg_addr(reg_addr), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .i_mem_rvalid(mem_rvalid), .o_ce_a(ce_a), .o_ce_cy(ce_cy),
    .i_flag_z(flag_z), .i_flag_cy(flag_cy), .o_halted(halted), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b1; instr = 16'h1205; mem_rvalid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({instr_ready, mem_rd, ce_a, ce_cy, halted, err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {instr_ready, mem_rd, ce_a, ce_cy, halted, err});
    end
    n_tests++;
    if ({data_src, op, immediate, reg_addr, mem_addr} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", {data_src, op, immediate, reg_addr, mem_addr});
    end
    next_cycle();
    rst_n = 1'b1; instr_valid = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 1", instr_ready);
    end
    next_cycle();
  endtask

  task automatic test_alu_imm();
    instr_valid = 1'b1; instr = 16'h1205;
    @(negedge clk);
    n_tests++;
    if ({instr_ready, ce_a} !== 2'b10) begin
      n_fail++; $display("FAIL imm_hs: ready,ce_a got %b required 10", {instr_ready, ce_a});
    end
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({instr_ready, ce_a, ce_cy, data_src, op, immediate} !== {1'b0, 1'b1, 1'b0, 2'b01, 3'd2, 8'h05}) begin
      n_fail++; $display("FAIL imm_exec: got %h required %h", {instr_ready, ce_a, ce_cy, data_src, op, immediate},
                         {1'b0, 1'b1, 1'b0, 2'b01, 3'd2, 8'h05});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({instr_ready, ce_a} !== 2'b10) begin
      n_fail++; $display("FAIL imm_return: ready,ce_a got %b required 10", {instr_ready, ce_a});
    end
    next_cycle();
  endtask

  task automatic test_alu_mem();
    int rd_cnt = 0;
    instr_valid = 1'b1; instr = 16'h3840; mem_rvalid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ce_a !== 1'b0) begin
      n_fail++; $display("FAIL mem_rvalid_idle: ce_a got %b required 0", ce_a);
    end
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    rd_cnt += int'(mem_rd);
    n_tests++;
    if ({mem_rd, ce_a, mem_addr, data_src} !== {1'b1, 1'b0, 8'h40, 2'b00}) begin
      n_fail++; $display("FAIL mem_req: got %h required %h", {mem_rd, ce_a, mem_addr, data_src}, {1'b1, 1'b0, 8'h40, 2'b00});
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      mem_rvalid = (k == 3);
      @(negedge clk);
      rd_cnt += int'(mem_rd);
      n_tests++;
      if ({ce_a, ce_cy} !== ((k == 3) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("FAIL mem_wait%0d: ce_a,ce_cy got %b required %b", k, {ce_a, ce_cy}, (k == 3) ? 2'b11 : 2'b00);
      end
    end
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({instr_ready, ce_a, rd_cnt} !== {1'b1, 1'b0, 32'd1}) begin
      n_fail++; $display("FAIL mem_done: ready=%b ce_a=%b mem_rd pulses=%0d required 1 0 1", instr_ready, ce_a, rd_cnt);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    for (int late = 0; late < 2; late++) begin
      instr_valid = 1'b1; instr = 16'h3100;
      next_cycle();
      instr_valid = 1'b0;
      next_cycle();
      for (int k = 1; k <= 15; k++) begin
        mem_rvalid = (late == 1 && k == 15);
        @(negedge clk);
        n_tests++;
        if ({ce_a, err} !== {(late == 1 && k == 15), 1'b0}) begin
          n_fail++; $display("FAIL timeout_wait late=%0d cyc=%0d: ce_a,err got %b required %b0", late, k, {ce_a, err}, (late == 1 && k == 15));
        end
        next_cycle();
      end
      mem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({err, ce_a, instr_ready} !== {(late == 0), 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL timeout_end late=%0d: err,ce_a,ready got %b required %b01", late, {err, ce_a, instr_ready}, (late == 0));
      end
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_err_width late=%0d: err got %b required 0", late, err);
      end
      next_cycle();
    end
  endtask

  task automatic test_skip();
    flag_z = 1'b1; instr_valid = 1'b1; instr = 16'h4000;
    next_cycle();
    instr = 16'hF000;
    @(negedge clk);
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL skz_ready: got %b required 1", instr_ready);
    end
    next_cycle();
    instr = 16'h2003;
    @(negedge clk);
    n_tests++;
    if ({halted, instr_ready} !== 2'b01) begin
      n_fail++; $display("FAIL skz_halt_skipped: halted,ready got %b required 01", {halted, instr_ready});
    end
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ce_a, reg_addr, data_src} !== {1'b1, 4'd3, 2'b11}) begin
      n_fail++; $display("FAIL skz_alu_reg: got %h required %h", {ce_a, reg_addr, data_src}, {1'b1, 4'd3, 2'b11});
    end
    next_cycle();
    flag_z = 1'b0; instr_valid = 1'b1; instr = 16'h4000;
    next_cycle();
    instr = 16'hF000;
    next_cycle();
    instr = 16'h2003;
    @(negedge clk);
    n_tests++;
    if ({halted, instr_ready} !== 2'b10) begin
      n_fail++; $display("FAIL noskip_halt: halted,ready got %b required 10", {halted, instr_ready});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if ({halted, ce_a} !== 2'b10) begin
      n_fail++; $display("FAIL halt_hold: halted,ce_a got %b required 10", {halted, ce_a});
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_illegal();
    instr_valid = 1'b1; instr = 16'h9000;
    @(negedge clk);
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({err, ce_a, instr_ready} !== 3'b101) begin
      n_fail++; $display("FAIL illegal_err: err,ce_a,ready got %b required 101", {err, ce_a, instr_ready});
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_err_width: err got %b required 0", err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    instr_valid = 1'b1; instr = 16'h3A55;
    next_cycle();
    instr_valid = 1'b0;
    next_cycle();
    mem_rvalid = 1'b1; rst_n = 1'b0;
    #1;
    n_tests++;
    if ({instr_ready, mem_rd, ce_a, ce_cy, halted, err, data_src, op, immediate, reg_addr, mem_addr} !== '0) begin
      n_fail++; $display("FAIL rst_mem_wait: got %h required 0",
                         {instr_ready, mem_rd, ce_a, ce_cy, halted, err, data_src, op, immediate, reg_addr, mem_addr});
    end
    next_cycle();
    mem_rvalid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({instr_ready, ce_a} !== 2'b10) begin
      n_fail++; $display("FAIL rst_release: ready,ce_a got %b required 10", {instr_ready, ce_a});
    end
    next_cycle();
    instr_valid = 1'b1; instr = 16'h1905;
    next_cycle();
    instr_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ce_a, ce_cy, op} !== 5'b0) begin
      n_fail++; $display("FAIL rst_exec: ce_a,ce_cy,op got %b required 00000", {ce_a, ce_cy, op});
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int pulses = 0;
    logic [3:0] exp_reg;
    for (int c = 0; c <= 8; c++) begin
      instr_valid = (idx < 4);
      instr = {4'h2, 1'b0, 3'd5, 4'h0, 4'(idx + 1)};
      @(negedge clk);
      n_tests++;
      if (instr_ready !== (c % 2 == 0)) begin
        n_fail++; $display("FAIL b2b_ready cyc=%0d: got %b required %b", c, instr_ready, (c % 2 == 0));
      end
      if (c % 2 == 1) begin
        exp_reg = 4'(c / 2 + 1);
        n_tests++;
        if ({ce_a, reg_addr} !== {1'b1, exp_reg}) begin
          n_fail++; $display("FAIL b2b_exec cyc=%0d: ce_a,reg got %h required %h", c, {ce_a, reg_addr}, {1'b1, exp_reg});
        end
      end
      pulses += int'(ce_a);
      if (instr_ready && instr_valid) idx++;
      next_cycle();
    end
    instr_valid = 1'b0;
    n_tests++;
    if (idx != 4 || pulses != 4) begin
      n_fail++; $display("FAIL b2b_count: handshakes=%0d ce_a pulses=%0d required 4 4", idx, pulses);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; mem_rvalid = 1'b0;
    flag_z = 1'b0; flag_cy = 1'b0;
    test_reset();
    test_alu_imm();
    test_alu_mem();
    test_timeout();
    test_skip();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
